wb_buffer: RTL and testbench
============================

Name: wb_buffer

Overview:
- Write-back buffer that sits directly upstream of the 32x32 register file and drives its single write port (wen/waddr/wdata).
- Queues completed results from the execute/memory stage in a small FIFO and drains them in order, one per cycle, whenever the write port is granted.
- Provides a youngest-match bypass lookup so operand reads can see results that are still pending.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- DATA_WIDTH, 32, result width; matches the register file data width.
- ADDR_WIDTH, 5, register index width; matches the register file address width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  producer has a result.
- in_ready  output  1  buffer can accept; equals (count < DEPTH).
- in_addr  input  ADDR_WIDTH  destination register index.
- in_data  input  DATA_WIDTH  result value.
- drain_en  input  1  write port granted this cycle.
- rf_wen  output  1  to register file wen.
- rf_waddr  output  ADDR_WIDTH  to register file waddr.
- rf_wdata  output  DATA_WIDTH  to register file wdata.
- lk_addr1  input  ADDR_WIDTH  bypass lookup index, read port 1.
- lk_addr2  input  ADDR_WIDTH  bypass lookup index, read port 2.
- lk_hit1  output  1  pending entry found for lk_addr1.
- lk_hit2  output  1  pending entry found for lk_addr2.
- lk_data1  output  DATA_WIDTH  youngest pending value for lk_addr1, 0 on miss.
- lk_data2  output  DATA_WIDTH  youngest pending value for lk_addr2, 0 on miss.
- count  output  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (asynchronous, rst=1): head=tail=count=0 and all entry valid bits cleared.
  - Resulting outputs: in_ready=1, rf_wen=0, rf_waddr=0, rf_wdata=0, lk_hit*=0, lk_data*=0, count=0.
  - Reset mid-operation discards every pending entry; none of them is written.
- Enqueue: fires when in_valid && in_ready at a rising edge; stores {in_addr, in_data} at tail; tail advances modulo DEPTH.
  - in_addr == 0 is accepted (handshake completes) but not stored; count and tail are unchanged.
- Dequeue (combinational outputs): rf_wen = drain_en && (count != 0).
  - rf_waddr/rf_wdata present the head entry when count != 0, and 0 otherwise.
  - When rf_wen=1 at an edge, head advances modulo DEPTH and the register file writes at that same edge.
  - Latency from enqueue to register-file write is at least 1 cycle: an entry enqueued at edge N can be written at edge N+1.
- Simultaneous enqueue and dequeue: count is unchanged.
  - When full, in_ready=0 even if a dequeue occurs in the same cycle; there is no full-cycle pass-through.
- count: +1 on a stored enqueue only, -1 on a dequeue only, unchanged when both or neither occur.
- Wrap-around: head and tail are ADDR-free circular pointers of clog2(DEPTH) bits; full/empty are decided by count, never by pointer equality.
- Ordering: strictly FIFO; multiple entries for the same register drain oldest first, so the final architectural value is the youngest.
- Bypass lookup (combinational):
  - Searches all valid entries; the youngest entry (closest to tail) with a matching address wins.
  - lk_addr == 0 never hits.
  - The entry being drained this cycle still participates in the lookup.
  - The same-cycle in_data is NOT forwarded.
- in_ready is a function of count only, with no combinational path from in_valid.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: lookup logic as described above.
- Undefined: lookup logic is removed; lk_hit1/2=0 and lk_data1/2=0 constantly. Ports are retained so integration is unchanged.

Test Plan:
- Reset then idle -> in_ready=1, rf_wen=0, count=0, lk_hit*=0.
- Enqueue (3, 0x11111111) with drain_en=1 -> next cycle rf_wen=1, rf_waddr=3, rf_wdata=0x11111111; count returns to 0 after that edge.
- drain_en=0; enqueue 4 entries addr 1..4, data 0xA1..0xA4 -> count=4, in_ready=0; a 5th in_valid is held.
  - Then drain_en=1 -> writes 1,2,3,4 in order on consecutive cycles and in_ready rises after the first dequeue.
- drain_en=0; enqueue (7, 0xAAAA) then (7, 0xBBBB); lk_addr1=7 -> lk_hit1=1, lk_data1=0xBBBB.
  - lk_addr2=0 -> lk_hit2=0.
  - With WB_BYPASS_EN undefined -> lk_hit1=0.
- Enqueue (0, 0xDEAD) -> handshake completes, count stays 0, no rf_wen.
- Full buffer, assert rst mid-stream for 1 cycle -> count=0, rf_wen=0 immediately; none of the discarded entries is ever written.
  - Wrap-around: 10 enqueue/dequeue pairs with DEPTH=4 -> write order and data exactly match enqueue order.

Source files
------------

// File: rtl/wb_buffer.sv
// wb_buffer: write-back buffer in front of the 32x32 register file.
//
// Completed results are queued in a DEPTH-entry FIFO and drained in order,
// one per cycle, onto the register file's single write port whenever
// drain_en grants it. Writes to register 0 are accepted but dropped.
//
// Optional feature macro: WB_BYPASS_EN
//   defined   : youngest-match bypass lookup on lk_addr1/lk_addr2
//   undefined : lk_hit*/lk_data* tied to 0 (ports kept for integration)
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   in_valid/in_ready            producer handshake (in_ready = count < DEPTH)
//   in_addr, in_data             destination register and result value
//   drain_en                     write port granted this cycle
//   rf_wen, rf_waddr, rf_wdata   register file write port (combinational)
//   lk_addr1/2                   bypass lookup indices
//   lk_hit1/2, lk_data1/2        bypass results (0 on miss)
//   count                        current occupancy
module wb_buffer #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_WIDTH-1:0]     in_addr,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      drain_en,
  output logic                      rf_wen,
  output logic [ADDR_WIDTH-1:0]     rf_waddr,
  output logic [DATA_WIDTH-1:0]     rf_wdata,
  input  logic [ADDR_WIDTH-1:0]     lk_addr1,
  input  logic [ADDR_WIDTH-1:0]     lk_addr2,
  output logic                      lk_hit1,
  output logic                      lk_hit2,
  output logic [DATA_WIDTH-1:0]     lk_data1,
  output logic [DATA_WIDTH-1:0]     lk_data2,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [DEPTH-1:0]      valid;
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;

  logic not_empty;
  logic enq_store;

  // Full/empty come from count only; head==tail is ambiguous.
  assign not_empty = (count != '0);
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign rf_wen    = drain_en && not_empty;
  assign rf_waddr  = not_empty ? mem_addr[head] : '0;
  assign rf_wdata  = not_empty ? mem_data[head] : '0;

  // Register 0 completes the handshake but is never stored.
  assign enq_store = in_valid && in_ready && (in_addr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (rf_wen) begin
        head        <= head + 1'b1;
        valid[head] <= 1'b0;
      end
      if (enq_store) begin
        tail        <= tail + 1'b1;
        valid[tail] <= 1'b1;
      end
      if (enq_store && !rf_wen) begin
        count <= count + 1'b1;
      end else if (!enq_store && rf_wen) begin
        count <= count - 1'b1;
      end
    end
  end

  // Payload storage carries no reset; valid bits qualify every use.
  always_ff @(posedge clk) begin
    if (enq_store) begin
      mem_addr[tail] <= in_addr;
      mem_data[tail] <= in_data;
    end
  end

`ifdef WB_BYPASS_EN
  // Walk entries oldest to youngest so a later match overrides an earlier
  // one; the entry draining this cycle is still valid here.
  always_comb begin
    logic [PTR_W-1:0] idx;
    lk_hit1  = 1'b0;
    lk_hit2  = 1'b0;
    lk_data1 = '0;
    lk_data2 = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (valid[idx] && (lk_addr1 != '0) && (mem_addr[idx] == lk_addr1)) begin
        lk_hit1  = 1'b1;
        lk_data1 = mem_data[idx];
      end
      if (valid[idx] && (lk_addr2 != '0) && (mem_addr[idx] == lk_addr2)) begin
        lk_hit2  = 1'b1;
        lk_data2 = mem_data[idx];
      end
    end
  end
`else
  logic unused_lk;
  assign unused_lk = ^{lk_addr1, lk_addr2, valid};
  assign lk_hit1   = 1'b0;
  assign lk_hit2   = 1'b0;
  assign lk_data1  = '0;
  assign lk_data2  = '0;
`endif

endmodule

// File: tb/tb_wb_buffer.sv
module tb_wb_buffer;

  localparam int DEPTH      = 4;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int CNT_W      = $clog2(DEPTH) + 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  drain_en;
  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic [ADDR_WIDTH-1:0] lk_addr1;
  logic [ADDR_WIDTH-1:0] lk_addr2;
  logic                  lk_hit1;
  logic                  lk_hit2;
  logic [DATA_WIDTH-1:0] lk_data1;
  logic [DATA_WIDTH-1:0] lk_data2;
  logic [CNT_W-1:0]      count;

  wb_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .drain_en(drain_en),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .lk_addr1(lk_addr1), .lk_addr2(lk_addr2),
    .lk_hit1(lk_hit1), .lk_hit2(lk_hit2), .lk_data1(lk_data1), .lk_data2(lk_data2),
    .count(count)
  );

  always #5 clk = ~clk;

  // Reference model: pending results as an ordered list, oldest at index 0.
  typedef struct {
    logic [ADDR_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] d;
  } ent_t;
  ent_t q[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Youngest pending result for a register; register 0 never matches.
  function automatic void model_lookup(input logic [ADDR_WIDTH-1:0] a,
                                       output logic hit, output logic [DATA_WIDTH-1:0] d);
    hit = 1'b0;
    d   = '0;
`ifdef WB_BYPASS_EN
    if (a != 0) begin
      for (int k = q.size() - 1; k >= 0; k--) begin
        if (q[k].a == a) begin
          hit = 1'b1;
          d   = q[k].d;
          break;
        end
      end
    end
`endif
  endfunction

  task automatic check_outputs();
    logic                  h1, h2;
    logic [DATA_WIDTH-1:0] d1, d2;
    model_lookup(lk_addr1, h1, d1);
    model_lookup(lk_addr2, h2, d2);
    chk("count",    64'(count),    64'(q.size()));
    chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    chk("rf_wen",   64'(rf_wen),   64'(drain_en && q.size() != 0));
    chk("rf_waddr", 64'(rf_waddr), q.size() != 0 ? 64'(q[0].a) : 64'd0);
    chk("rf_wdata", 64'(rf_wdata), q.size() != 0 ? 64'(q[0].d) : 64'd0);
    chk("lk_hit1",  64'(lk_hit1),  64'(h1));
    chk("lk_data1", 64'(lk_data1), 64'(d1));
    chk("lk_hit2",  64'(lk_hit2),  64'(h2));
    chk("lk_data2", 64'(lk_data2), 64'(d2));
  endtask

  // One clock cycle: drive after the falling edge, check, then advance the
  // model by the rules for the rising edge.
  task automatic step(input logic v, input logic [ADDR_WIDTH-1:0] a,
                      input logic [DATA_WIDTH-1:0] d, input logic dr,
                      input logic [ADDR_WIDTH-1:0] l1, input logic [ADDR_WIDTH-1:0] l2);
    bit rdy;
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    drain_en = dr;
    lk_addr1 = l1;
    lk_addr2 = l2;
    #1;
    check_outputs();
    rdy = (q.size() < DEPTH);
    @(posedge clk);
    if (dr && q.size() != 0) void'(q.pop_front());
    if (v && rdy && a != 0) q.push_back('{a: a, d: d});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, '0, 1'b1, '0, '0);
  endtask

  initial begin
    logic [ADDR_WIDTH-1:0] ra, l1, l2;
    rst = 1'b1; in_valid = 0; in_addr = '0; in_data = '0; drain_en = 0;
    lk_addr1 = '0; lk_addr2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state and idle.
    step(1'b0, '0, '0, 1'b0, 5'd3, 5'd0);

    // Single enqueue with drain granted: written on the next cycle.
    step(1'b1, 5'd3, 32'h11111111, 1'b1, 5'd3, '0);
    step(1'b0, '0, '0, 1'b1, 5'd3, '0);
    step(1'b0, '0, '0, 1'b1, '0, '0);

    // Fill to DEPTH with drain off, hold a fifth, then drain in order.
    for (int i = 1; i <= 4; i++) step(1'b1, 5'(i), 32'hA0 + 32'(i), 1'b0, 5'(i), 5'd2);
    step(1'b1, 5'd5, 32'hA5, 1'b0, 5'd4, '0);
    for (int i = 0; i < 6; i++) step(1'b1, 5'd5, 32'hA5, 1'b1, 5'd5, 5'd3);
    idle(2);

    // Same register twice: lookup returns the younger value.
    step(1'b1, 5'd7, 32'hAAAA, 1'b0, 5'd7, '0);
    step(1'b1, 5'd7, 32'hBBBB, 1'b0, 5'd7, '0);
    step(1'b0, '0, '0, 1'b0, 5'd7, 5'd0);
    step(1'b1, 5'd9, 32'hCCCC, 1'b1, 5'd7, 5'd9);
    idle(4);

    // Register 0 handshake: accepted, never stored.
    step(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 5'd0);
    step(1'b0, '0, '0, 1'b1, '0, '0);

    // Full buffer, then asynchronous reset mid-stream.
    for (int i = 0; i < 4; i++) step(1'b1, 5'd10 + 5'(i), 32'hF00 + 32'(i), 1'b0, '0, '0);
    in_valid = 1'b1; in_addr = 5'd20; in_data = 32'h5555; drain_en = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_wen",   64'(rf_wen), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(3);

    // Wrap-around: ten enqueue/dequeue pairs.
    step(1'b1, 5'd1, 32'h1000, 1'b0, '0, '0);
    for (int i = 0; i < 10; i++)
      step(1'b1, 5'(2 + i), 32'h2000 + 32'(i), 1'b1, 5'(2 + i), 5'(1 + i));
    idle(3);

    // Randomised traffic over a small address range for frequent aliasing.
    for (int n = 0; n < 400; n++) begin
      ra = 5'($urandom_range(0, 7));
      l1 = 5'($urandom_range(0, 7));
      l2 = 5'($urandom_range(0, 7));
      if (q.size() != 0 && $urandom_range(0, 1) == 1) l1 = q[$urandom_range(0, q.size() - 1)].a;
      step($urandom_range(0, 3) != 0, ra, $urandom, $urandom_range(0, 2) != 0, l1, l2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
